// File: rtl/if_stage_2.sv
// -----------------------------------------------------------------------------
// if_stage_2 -- second instruction-fetch stage.
//
// Takes the packet produced by fetch stage 1 (PC, stage-1 exception, branch
// prediction). It waits for the matching icache response and hands a
// registered packet to decode. Decode backpressure is absorbed in a HOLD state.
// A flush kills held work. A response that belongs to a request killed while
// it was outstanding is later discarded.
//
// Build option:
//   FETCH_TIMEOUT_EN  when defined, a 16-bit wait counter and a RETRY state are
//                     added. After TIMEOUT_CYCLES cycles in WAIT without a
//                     response, a one-cycle re-request pulse is issued. When
//                     undefined, WAIT waits indefinitely and retry_fetch_o is
//                     tied low.
//
// Parameters:
//   TIMEOUT_CYCLES     cycles spent in WAIT before a fetch retry (default 64)
//
// Ports:
//   clk_i              single clock
//   rst_i              synchronous, active-high reset
//   stall_i            decode cannot accept a packet this cycle
//   flush_i            kill from the control unit
//   fetch_i            packet from stage 1 (valid, pc_inst, ex, bpred)
//   resp_icache_cpu_i  icache response (valid, data, xcpt)
//   stall_o            combinational backpressure to stage 1
//   retry_fetch_o      one-cycle re-request pulse to stage 1 and the icache
//   decode_o           registered packet to decode (valid, pc_inst, inst, ex, bpred)
// -----------------------------------------------------------------------------

package if_stage_2_pkg;

  localparam logic [5:0] INSTR_ADDR_MISALIGNED = 6'd0;
  localparam logic [5:0] INSTR_PAGE_FAULT      = 6'd12;

  typedef struct packed {
    logic        valid;
    logic [5:0]  cause;
    logic [31:0] origin;
  } exception_t;

  typedef struct packed {
    logic        decision;
    logic [31:0] pred_addr;
  } bpred_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_inst;
    exception_t  ex;
    bpred_t      bpred;
  } if_1_if_2_stage_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        xcpt;
  } resp_icache_cpu_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_inst;
    logic [31:0] inst;
    exception_t  ex;
    bpred_t      bpred;
  } if_id_stage_t;

endpackage

module if_stage_2
  import if_stage_2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  if_1_if_2_stage_t fetch_i,
  input  resp_icache_cpu_t resp_icache_cpu_i,
  output logic             stall_o,
  output logic             retry_fetch_o,
  output if_id_stage_t     decode_o
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    RETRY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;
`endif

  state_t       state_r;
  if_id_stage_t decode_r;
  // Set when a request was killed while outstanding at the icache. Its late
  // response must not complete the next fetch.
  logic         drop_pending_r;
  logic         in_flight_s;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] WAIT_CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
  logic [15:0]  wait_cnt_r;
  logic         retry_r;
`endif

  // Backpressure to stage 1, and whether the icache still owes us a response.
  always_comb begin
    stall_o     = 1'b0;
    in_flight_s = 1'b0;
    case (state_r)
      WAIT: begin
        stall_o     = ~resp_icache_cpu_i.valid;
        in_flight_s = 1'b1;
      end
      HOLD: begin
        stall_o     = stall_i;
        in_flight_s = 1'b0;
      end
`ifdef FETCH_TIMEOUT_EN
      RETRY: begin
        stall_o     = 1'b1;
        in_flight_s = 1'b1;
      end
`endif
      default: begin
        stall_o     = 1'b0;
        in_flight_s = 1'b0;
      end
    endcase
  end

  // Fetch-completion FSM with registered decode packet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r        <= IDLE;
      decode_r       <= '0;
      drop_pending_r <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_r     <= 16'd0;
      retry_r        <= 1'b0;
`endif
    end else if (flush_i) begin
      // A flush wins over everything. Whatever arrives this cycle is ignored.
      state_r        <= IDLE;
      decode_r.valid <= 1'b0;
      drop_pending_r <= drop_pending_r | in_flight_s;
`ifdef FETCH_TIMEOUT_EN
      retry_r        <= 1'b0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      retry_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          decode_r.valid <= 1'b0;
          if (fetch_i.valid) begin
            decode_r.pc_inst <= fetch_i.pc_inst;
            decode_r.bpred   <= fetch_i.bpred;
            decode_r.ex      <= fetch_i.ex;
            if (fetch_i.ex.valid) begin
              // Stage-1 exception: nothing was sent to the icache.
              decode_r.valid <= 1'b1;
              decode_r.inst  <= 32'h0000_0000;
              state_r        <= HOLD;
            end else begin
              state_r <= WAIT;
`ifdef FETCH_TIMEOUT_EN
              wait_cnt_r <= 16'd0;
`endif
            end
          end else begin
            state_r <= IDLE;
          end
        end

        WAIT: begin
          if (resp_icache_cpu_i.valid) begin
            if (drop_pending_r) begin
              // Stale response of a killed request. Keep waiting for ours.
              drop_pending_r <= 1'b0;
              state_r        <= WAIT;
`ifdef FETCH_TIMEOUT_EN
              wait_cnt_r     <= 16'd0;
`endif
            end else begin
              decode_r.valid <= 1'b1;
              decode_r.inst  <= resp_icache_cpu_i.data;
              if (resp_icache_cpu_i.xcpt) begin
                decode_r.ex.valid  <= 1'b1;
                decode_r.ex.cause  <= INSTR_PAGE_FAULT;
                decode_r.ex.origin <= decode_r.pc_inst;
              end else begin
                decode_r.ex <= decode_r.ex;
              end
              state_r <= stall_i ? HOLD : IDLE;
            end
          end else begin
`ifdef FETCH_TIMEOUT_EN
            // A response in the same cycle takes the branch above, so it
            // always beats the timeout.
            if (wait_cnt_r == WAIT_CNT_LAST) begin
              state_r <= RETRY;
              retry_r <= 1'b1;
            end else begin
              wait_cnt_r <= wait_cnt_r + 16'd1;
              state_r    <= WAIT;
            end
`else
            state_r <= WAIT;
`endif
          end
        end

        HOLD: begin
          // The packet stays untouched until decode takes it.
          if (!stall_i) begin
            decode_r.valid <= 1'b0;
            state_r        <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end

`ifdef FETCH_TIMEOUT_EN
        RETRY: begin
          state_r    <= WAIT;
          wait_cnt_r <= 16'd0;
        end
`endif

        default: begin
          decode_r.valid <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

  assign decode_o = decode_r;

`ifdef FETCH_TIMEOUT_EN
  assign retry_fetch_o = retry_r;
`else
  // No retry machinery in this build. The parameter has no effect here.
  assign retry_fetch_o = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif

endmodule

// File: tb/tb_if_stage_2.sv
// -----------------------------------------------------------------------------
// Self-checking bench for if_stage_2.
//
// A table of per-cycle vectors drives the main scenarios. These are a hit,
// backpressure, a stage-1 exception, an icache exception, and a flush while
// waiting followed by a stale response. Hand-written sequences cover the
// timeout, reset mid-WAIT and reset mid-HOLD. Expected decode packets are
// queued when their stimulus is driven. They are popped when decode consumes
// a packet, which happens when valid is set and stall_i is low.
// -----------------------------------------------------------------------------
module tb_if_stage_2;
  import if_stage_2_pkg::*;

  localparam int unsigned TMO = 4;
`ifdef FETCH_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             stall_i;
  logic             flush_i;
  if_1_if_2_stage_t fetch_i;
  resp_icache_cpu_t resp_icache_cpu_i;
  logic             stall_o;
  logic             retry_fetch_o;
  if_id_stage_t     decode_o;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exv;
    logic [5:0]  cause;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        st, fl, fv;
    logic [31:0] pc;
    logic        fex;
    logic [5:0]  fc;
    logic        rv;
    logic [31:0] data;
    logic        xc;
    logic        e_stall_o, e_dv, push;
    logic [31:0] e_inst;
    logic        e_exv;
    logic [5:0]  e_cause;
  } vec_t;
  localparam int NV = 28;
  vec_t vec [NV];

  logic         hold_prev;
  if_id_stage_t prev_pkt;

  if_stage_2 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .fetch_i           (fetch_i),
    .resp_icache_cpu_i (resp_icache_cpu_i),
    .stall_o           (stall_o),
    .retry_fetch_o     (retry_fetch_o),
    .decode_o          (decode_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic st, input logic fl, input logic fv, input logic [31:0] pc,
                       input logic fex, input logic [5:0] fc, input logic rv,
                       input logic [31:0] data, input logic xc);
    stall_i                  = st;
    flush_i                  = fl;
    fetch_i.valid            = fv;
    fetch_i.pc_inst          = pc;
    fetch_i.ex.valid         = fex;
    fetch_i.ex.cause         = fc;
    fetch_i.ex.origin        = pc;
    fetch_i.bpred.decision   = 1'b1;
    fetch_i.bpred.pred_addr  = pc + 32'd4;
    resp_icache_cpu_i.valid  = rv;
    resp_icache_cpu_i.data   = data;
    resp_icache_cpu_i.xcpt   = xc;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic exv,
                      input logic [5:0] cause);
    sb_q.push_back('{pc, inst, exv, cause});
  endtask

  // Scoreboard: compare every consumed packet and check HOLD stability.
  always @(negedge clk_i) begin
    if (rst_i) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) check("hold_stable", 64'(decode_o == prev_pkt), 64'd1);
      if (decode_o.valid && !stall_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL pkt_unexpected: got pc 0x%0h inst 0x%0h, expected no packet",
                   decode_o.pc_inst, decode_o.inst);
        end else begin
          check("pkt_pc", 64'(decode_o.pc_inst), 64'(sb_q[0].pc));
          check("pkt_inst", 64'(decode_o.inst), 64'(sb_q[0].inst));
          check("pkt_exv", 64'(decode_o.ex.valid), 64'(sb_q[0].exv));
          check("pkt_bpred", 64'({decode_o.bpred.decision, decode_o.bpred.pred_addr}),
                64'({1'b1, sb_q[0].pc + 32'd4}));
          if (sb_q[0].exv) begin
            check("pkt_cause", 64'(decode_o.ex.cause), 64'(sb_q[0].cause));
            check("pkt_origin", 64'(decode_o.ex.origin), 64'(sb_q[0].pc));
          end
          void'(sb_q.pop_front());
        end
      end
      hold_prev <= decode_o.valid && stall_i && !flush_i;
      prev_pkt  <= decode_o;
    end
  end

  initial begin
    // Columns: st fl fv pc fex fc rv data xc | e_stall_o e_dv push e_inst e_exv e_cause
    // Hit: fetch, response next cycle, packet the cycle after.
    vec[0]  = '{0,0,1,32'h8000_0000,0,6'd0,0,32'h0,0,        0,0,0,32'h0,0,6'd0};
    vec[1]  = '{0,0,0,32'h8000_0000,0,6'd0,1,32'h13,0,       0,0,1,32'h13,0,6'd0};
    vec[2]  = '{0,0,0,32'h8000_0000,0,6'd0,0,32'h0,0,        0,1,0,32'h0,0,6'd0};
    // Backpressure: response under stall_i, three held cycles, consumed on the fourth.
    vec[3]  = '{0,0,1,32'h8000_0004,0,6'd0,0,32'h0,0,        0,0,0,32'h0,0,6'd0};
    vec[4]  = '{0,0,0,32'h8000_0004,0,6'd0,0,32'h0,0,        1,0,0,32'h0,0,6'd0};
    vec[5]  = '{1,0,0,32'h8000_0004,0,6'd0,1,32'h0010_0093,0,0,0,1,32'h0010_0093,0,6'd0};
    vec[6]  = '{1,0,0,32'h8000_0004,0,6'd0,0,32'h0,0,        1,1,0,32'h0,0,6'd0};
    vec[7]  = '{1,0,0,32'h8000_0004,0,6'd0,0,32'h0,0,        1,1,0,32'h0,0,6'd0};
    vec[8]  = '{1,0,0,32'h8000_0004,0,6'd0,0,32'h0,0,        1,1,0,32'h0,0,6'd0};
    vec[9]  = '{0,0,0,32'h8000_0004,0,6'd0,0,32'h0,0,        0,1,0,32'h0,0,6'd0};
    // Stage-1 misaligned exception: packet next cycle, no icache wait.
    vec[10] = '{0,0,1,32'h8000_0002,1,INSTR_ADDR_MISALIGNED,0,32'h0,0, 0,0,1,32'h0,1,INSTR_ADDR_MISALIGNED};
    vec[11] = '{0,0,0,32'h8000_0002,0,6'd0,0,32'h0,0,        0,1,0,32'h0,0,6'd0};
    // Icache exception.
    vec[12] = '{0,0,1,32'h8000_0008,0,6'd0,0,32'h0,0,        0,0,0,32'h0,0,6'd0};
    vec[13] = '{0,0,0,32'h8000_0008,0,6'd0,1,32'hDEAD_BEEF,1,0,0,1,32'hDEAD_BEEF,1,INSTR_PAGE_FAULT};
    vec[14] = '{0,0,0,32'h8000_0008,0,6'd0,0,32'h0,0,        0,1,0,32'h0,0,6'd0};
    // Flush in WAIT, new fetch, stale 0xAAAA dropped, 0xBBBB completes.
    vec[15] = '{0,0,1,32'h8000_0010,0,6'd0,0,32'h0,0,        0,0,0,32'h0,0,6'd0};
    vec[16] = '{0,0,0,32'h8000_0010,0,6'd0,0,32'h0,0,        1,0,0,32'h0,0,6'd0};
    vec[17] = '{0,1,0,32'h8000_0010,0,6'd0,0,32'h0,0,        1,0,0,32'h0,0,6'd0};
    vec[18] = '{0,0,1,32'h8000_0020,0,6'd0,0,32'h0,0,        0,0,0,32'h0,0,6'd0};
    vec[19] = '{0,0,0,32'h8000_0020,0,6'd0,1,32'h0000_AAAA,0,0,0,0,32'h0,0,6'd0};
    vec[20] = '{0,0,0,32'h8000_0020,0,6'd0,1,32'h0000_BBBB,0,0,0,1,32'h0000_BBBB,0,6'd0};
    vec[21] = '{0,0,0,32'h8000_0020,0,6'd0,0,32'h0,0,        0,1,0,32'h0,0,6'd0};
    // Fetch coinciding with a flush is ignored.
    vec[22] = '{0,1,1,32'h8000_0030,0,6'd0,0,32'h0,0,        0,0,0,32'h0,0,6'd0};
    vec[23] = '{0,0,0,32'h8000_0030,0,6'd0,0,32'h0,0,        0,0,0,32'h0,0,6'd0};
    // Flush while holding a packet discards it.
    vec[24] = '{1,0,1,32'h8000_0040,1,INSTR_ADDR_MISALIGNED,0,32'h0,0, 0,0,0,32'h0,0,6'd0};
    vec[25] = '{1,0,0,32'h8000_0040,0,6'd0,0,32'h0,0,        1,1,0,32'h0,0,6'd0};
    vec[26] = '{1,1,0,32'h8000_0040,0,6'd0,0,32'h0,0,        1,1,0,32'h0,0,6'd0};
    vec[27] = '{0,0,0,32'h8000_0040,0,6'd0,0,32'h0,0,        0,0,0,32'h0,0,6'd0};

    // Reset state.
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 64'(decode_o.valid), 64'd0);
    check("rst_exv", 64'(decode_o.ex.valid), 64'd0);
    check("rst_pc", 64'(decode_o.pc_inst), 64'd0);
    check("rst_inst", 64'(decode_o.inst), 64'd0);
    check("rst_retry", 64'(retry_fetch_o), 64'd0);
    check("rst_stall_o", 64'(stall_o), 64'd0);
    step();
    rst_i = 1'b0;

    // Table-driven scenarios.
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].st, vec[i].fl, vec[i].fv, vec[i].pc, vec[i].fex, vec[i].fc,
            vec[i].rv, vec[i].data, vec[i].xc);
      if (vec[i].push) push(vec[i].pc, vec[i].e_inst, vec[i].e_exv, vec[i].e_cause);
      @(negedge clk_i);
      check($sformatf("v%0d_stall_o", i), 64'(stall_o), 64'(vec[i].e_stall_o));
      check($sformatf("v%0d_dvalid", i), 64'(decode_o.valid), 64'(vec[i].e_dv));
      check($sformatf("v%0d_retry", i), 64'(retry_fetch_o), 64'd0);
      step();
    end

    // Timeout: the retry pulse appears 4 cycles after entering WAIT, and a
    // response at cycle 7 still completes.
    drive(1'b0, 1'b0, 1'b1, 32'h8000_0050, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    step();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h8000_0050, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
      @(negedge clk_i);
      check($sformatf("tmo%0d_retry", k), 64'(retry_fetch_o), 64'(TO_EN & (k == 5)));
      check($sformatf("tmo%0d_stall_o", k), 64'(stall_o), 64'd1);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h8000_0050, 1'b0, 6'd0, 1'b1, 32'h0000_0093, 1'b0);
    push(32'h8000_0050, 32'h0000_0093, 1'b0, 6'd0);
    @(negedge clk_i);
    check("tmo7_stall_o", 64'(stall_o), 64'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    @(negedge clk_i);
    check("tmo8_dvalid", 64'(decode_o.valid), 64'd1);
    step();

    // Reset mid-HOLD abandons the held packet.
    drive(1'b1, 1'b0, 1'b1, 32'h8000_0060, 1'b1, INSTR_ADDR_MISALIGNED, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h8000_0060, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    @(negedge clk_i);
    check("rhold_dvalid", 64'(decode_o.valid), 64'd1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rhold_post_stall_o", 64'(stall_o), 64'd0);
    check("rhold_post_dvalid", 64'(decode_o.valid), 64'd0);
    step();

    // Reset mid-WAIT. The stale response after release is ignored, and a
    // fresh fetch then completes normally.
    drive(1'b0, 1'b0, 1'b1, 32'h8000_0070, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h8000_0070, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h8000_0070, 1'b0, 6'd0, 1'b1, 32'h0000_1111, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    @(negedge clk_i);
    check("rwait_dvalid", 64'(decode_o.valid), 64'd0);
    check("rwait_stall_o", 64'(stall_o), 64'd0);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'h8000_0080, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h8000_0080, 1'b0, 6'd0, 1'b1, 32'h0000_2222, 1'b0);
    push(32'h8000_0080, 32'h0000_2222, 1'b0, 6'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    @(negedge clk_i);
    check("rwait_new_dvalid", 64'(decode_o.valid), 64'd1);
    step();

    repeat (3) step();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
